// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: handshake strobes, data and status.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
);
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, rd, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr, rd, data_in,
    output data_out, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses; writes win over reads in the same cycle.
module sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  sync_fifo_if.slave  bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_s, empty_s;
  logic             wr_acc_s, rd_acc_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});

  // Request arbitration and next-state computation
  always_comb begin
    wr_acc_s = bus.wr && !full_s;
    rd_acc_s = bus.rd && !empty_s && !wr_acc_s;
    ovf_d    = bus.wr && full_s;
    udf_d    = bus.rd && empty_s && !wr_acc_s;
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc_s) begin
      // Explicit wrap keeps non-power-of-2 depths correct
      wp_d    = (wp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wp_q + PW'(1);
      count_d = count_q + CW'(1);
    end else if (rd_acc_s) begin
      rp_d    = (rp_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rp_q + PW'(1);
      count_d = count_q - CW'(1);
      dout_d  = mem_q[rp_q];
    end else begin
      count_d = count_q;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= {PW{1'b0}};
      rp_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      dout_q  <= {WIDTH{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (rst && wr_acc_s) begin
      mem_q[wp_q] <= bus.data_in;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=4, WIDTH=8) with hand-computed expectations.
module tb_sync_fifo;
  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  sync_fifo_if #(.WIDTH(8), .CW(3)) bus ();

  sync_fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given request; outputs settle 1 time unit after the edge
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic rs);
    bus.wr      = w;
    bus.rd      = r;
    bus.data_in = d;
    rst         = rs;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    rst    = 1'b1;
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = 8'h00;
    @(negedge clk);

    // Reset
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_count", bus.count,     32'd0);
    chk("rst_empty", bus.empty,     32'd1);
    chk("rst_full",  bus.full,      32'd0);
    chk("rst_dout",  bus.data_out,  32'd0);
    chk("rst_ovf",   bus.overflow,  32'd0);
    chk("rst_udf",   bus.underflow, 32'd0);

    // Fill
    cyc(1'b1, 1'b0, 8'd3, 1'b1); chk("fill_c1", bus.count, 32'd1);
    cyc(1'b1, 1'b0, 8'd7, 1'b1); chk("fill_c2", bus.count, 32'd2);
    cyc(1'b1, 1'b0, 8'd1, 1'b1); chk("fill_c3", bus.count, 32'd3);
    chk("fill_notfull", bus.full, 32'd0);
    cyc(1'b1, 1'b0, 8'd9, 1'b1); chk("fill_c4", bus.count, 32'd4);
    chk("fill_full", bus.full, 32'd1);
    cyc(1'b1, 1'b0, 8'd5, 1'b1);
    chk("ovf_pulse", bus.overflow, 32'd1);
    chk("ovf_count", bus.count, 32'd4);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("ovf_clear", bus.overflow, 32'd0);

    // Partial drain
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("drain_d3", bus.data_out, 32'd3);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("drain_d7", bus.data_out, 32'd7);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("drain_d1", bus.data_out, 32'd1);
    chk("drain_count", bus.count, 32'd1);
    chk("drain_full",  bus.full,  32'd0);
    chk("drain_empty", bus.empty, 32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("idle_hold", bus.data_out, 32'd1);

    // Pointer wrap
    cyc(1'b1, 1'b0, 8'd2, 1'b1);
    cyc(1'b1, 1'b0, 8'd4, 1'b1);
    cyc(1'b1, 1'b0, 8'd6, 1'b1);
    chk("wrap_full", bus.full, 32'd1);
    cyc(1'b1, 1'b0, 8'd8, 1'b1);
    chk("wrap_ovf",   bus.overflow, 32'd1);
    chk("wrap_count", bus.count,    32'd4);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("wrap_d9", bus.data_out, 32'd9);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("wrap_d2", bus.data_out, 32'd2);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("wrap_d4", bus.data_out, 32'd4);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("wrap_d6", bus.data_out, 32'd6);
    chk("wrap_empty", bus.empty, 32'd1);
    cyc(1'b0, 1'b1, 8'd0, 1'b1);
    chk("udf_pulse", bus.underflow, 32'd1);
    chk("udf_hold",  bus.data_out,  32'd6);
    chk("udf_empty", bus.empty,     32'd1);
    chk("udf_count", bus.count,     32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("udf_clear", bus.underflow, 32'd0);

    // Simultaneous read and write
    cyc(1'b1, 1'b0, 8'd20, 1'b1);
    cyc(1'b1, 1'b0, 8'd21, 1'b1);
    cyc(1'b1, 1'b1, 8'd11, 1'b1);
    chk("sim_count", bus.count,     32'd3);
    chk("sim_hold",  bus.data_out,  32'd6);
    chk("sim_noudf", bus.underflow, 32'd0);
    cyc(1'b1, 1'b0, 8'd22, 1'b1);
    chk("sim_full", bus.full, 32'd1);
    cyc(1'b1, 1'b1, 8'd23, 1'b1);
    chk("simf_ovf",   bus.overflow, 32'd1);
    chk("simf_dout",  bus.data_out, 32'd20);
    chk("simf_count", bus.count,    32'd3);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("ord_d21", bus.data_out, 32'd21);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("ord_d11", bus.data_out, 32'd11);
    cyc(1'b0, 1'b1, 8'd0, 1'b1); chk("ord_d22", bus.data_out, 32'd22);
    chk("ord_empty", bus.empty, 32'd1);

    // Mid-operation reset
    cyc(1'b1, 1'b0, 8'd30, 1'b1);
    cyc(1'b1, 1'b0, 8'd31, 1'b1);
    cyc(1'b1, 1'b0, 8'd32, 1'b1);
    chk("mid_pre", bus.count, 32'd3);
    cyc(1'b1, 1'b0, 8'd33, 1'b0);
    chk("mid_count", bus.count,    32'd0);
    chk("mid_empty", bus.empty,    32'd1);
    chk("mid_dout",  bus.data_out, 32'd0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b1);
    chk("post_count", bus.count, 32'd1);
    cyc(1'b0, 1'b1, 8'd0, 1'b1);
    chk("post_dout",  bus.data_out, 32'h5A);
    chk("post_empty", bus.empty,    32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
